// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD up/down timer.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int         NUM_DIGITS_DEFAULT = 4;
  localparam logic [3:0] BCD_MAX            = 4'd9;

  // Clamp an arbitrary nibble into the legal BCD range.
  function automatic logic [3:0] bcd_sat(input logic [3:0] d);
    if (d > BCD_MAX) begin
      return BCD_MAX;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/bcd_timer_if.sv
// Control/status bundle between the timer and its controller.
interface bcd_timer_if
  import bcd_timer_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT
);

  logic                    tick;
  logic                    start;
  logic                    stop;
  logic                    clear;
  logic                    load_en;
  logic [4*NUM_DIGITS-1:0] load_value;
  logic                    count_down;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    running;
  logic                    done;
  logic                    wrap;

  modport master (
    output tick, start, stop, clear, load_en, load_value, count_down,
    input  digits, running, done, wrap
  );

  modport slave (
    input  tick, start, stop, clear, load_en, load_value, count_down,
    output digits, running, done, wrap
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit of the counter chain; carry_out doubles as borrow_out when dir=1.
module bcd_digit
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_d,
  input  logic       clr,
  input  logic       carry_in,
  output logic       carry_out,
  output logic [3:0] q
);

  logic [3:0] q_r;
  logic [3:0] q_next_s;
  logic       at_limit_s;

  // Next digit value: clear beats load beats a rippled step.
  always_comb begin
    at_limit_s = dir ? (q_r == 4'd0) : (q_r == BCD_MAX);
    q_next_s   = q_r;
    if (clr) begin
      q_next_s = 4'd0;
    end else if (load) begin
      q_next_s = bcd_sat(load_d);
    end else if (en && carry_in) begin
      if (dir) begin
        q_next_s = at_limit_s ? BCD_MAX : (q_r - 4'd1);
      end else begin
        q_next_s = at_limit_s ? 4'd0 : (q_r + 4'd1);
      end
    end else begin
      q_next_s = q_r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= 4'd0;
    end else begin
      q_r <= q_next_s;
    end
  end

  assign carry_out = carry_in && at_limit_s;
  assign q         = q_r;

endmodule

// File: rtl/bcd_timer.sv
// Packed-BCD start/stop timer: control FSM plus a rippled chain of bcd_digit cells.
module bcd_timer
  import bcd_timer_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT
)(
  input  logic       clk_in,
  input  logic       reset,
  bcd_timer_if.slave bus
);

  localparam int            W   = 4 * NUM_DIGITS;
  localparam logic [W-1:0]  ONE = {{(W-1){1'b0}}, 1'b1};

  state_t          state_r;
  state_t          state_next_s;
  logic            step_s;
  logic            clr_s;
  logic            load_s;
  logic            done_next_s;
  logic            wrap_next_s;
  logic            done_r;
  logic            wrap_r;
  logic            running_r;
  logic [NUM_DIGITS:0] carry_s;
  logic [W-1:0]    digits_s;
  logic            limit_s;

  // The chain's final carry means "all nines" counting up and "all zeros" counting down.
  assign carry_s[0] = 1'b1;
  assign limit_s    = carry_s[NUM_DIGITS];

  // Control priority: clear > load_en > stop > start > tick.
  always_comb begin
    state_next_s = state_r;
    step_s       = 1'b0;
    clr_s        = 1'b0;
    load_s       = 1'b0;
    done_next_s  = 1'b0;
    wrap_next_s  = 1'b0;
    if (bus.clear) begin
      clr_s        = 1'b1;
      state_next_s = IDLE;
    end else if (bus.load_en) begin
      load_s       = 1'b1;
      state_next_s = (state_r == DONE) ? IDLE : state_r;
    end else if (bus.stop) begin
      state_next_s = (state_r == RUN) ? PAUSE : state_r;
    end else if (bus.start && ((state_r == IDLE) || (state_r == PAUSE))) begin
      state_next_s = RUN;
    end else if (bus.tick && (state_r == RUN)) begin
      if (bus.count_down) begin
        if (limit_s) begin
          // Already at zero: finish without underflowing.
          state_next_s = DONE;
          done_next_s  = 1'b1;
        end else if (digits_s == ONE) begin
          step_s       = 1'b1;
          state_next_s = DONE;
          done_next_s  = 1'b1;
        end else begin
          step_s       = 1'b1;
        end
      end else begin
        step_s      = 1'b1;
        wrap_next_s = limit_s;
      end
    end else begin
      state_next_s = state_r;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_r   <= IDLE;
      done_r    <= 1'b0;
      wrap_r    <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      done_r    <= done_next_s;
      wrap_r    <= wrap_next_s;
      running_r <= (state_next_s == RUN);
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk_in),
      .reset     (reset),
      .en        (step_s),
      .dir       (bus.count_down),
      .load      (load_s),
      .load_d    (bus.load_value[4*i +: 4]),
      .clr       (clr_s),
      .carry_in  (carry_s[i]),
      .carry_out (carry_s[i+1]),
      .q         (digits_s[4*i +: 4])
    );
  end

  assign bus.digits  = digits_s;
  assign bus.running = running_r;
  assign bus.done    = done_r;
  assign bus.wrap    = wrap_r;

endmodule

// File: tb/tb_bcd_timer.sv
// Scoreboard bench for bcd_timer: an integer-count reference model queues expectations per cycle.
module tb_bcd_timer;
  import bcd_timer_pkg::*;

  typedef struct packed {
    logic [15:0] digits;
    logic        running;
    logic        done;
    logic        wrap;
  } exp_t;

  logic   clk_in;
  logic   reset;
  int     n_cmp;
  int     n_err;
  exp_t   sb[$];
  state_t m_state;
  int     m_count;
  logic   m_done;
  logic   m_wrap;

  bcd_timer_if #(.NUM_DIGITS(4)) bus ();

  bcd_timer #(.NUM_DIGITS(4)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd_sat(input logic [15:0] lv);
    int sum;
    int mul;
    int n;
    sum = 0;
    mul = 1;
    for (int i = 0; i < 4; i++) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 9;
      sum = sum + n * mul;
      mul = mul * 10;
    end
    return sum;
  endfunction

  task automatic model_step(input logic rst, t, s, p, c, l, input logic [15:0] lv, input logic dn);
    m_done = 1'b0;
    m_wrap = 1'b0;
    if (rst) begin
      m_state = IDLE;
      m_count = 0;
    end else if (c) begin
      m_count = 0;
      m_state = IDLE;
    end else if (l) begin
      m_count = from_bcd_sat(lv);
      if (m_state == DONE) m_state = IDLE;
    end else if (p) begin
      if (m_state == RUN) m_state = PAUSE;
    end else if (s && (m_state == IDLE || m_state == PAUSE)) begin
      m_state = RUN;
    end else if (t && m_state == RUN) begin
      if (dn) begin
        if (m_count > 0) m_count = m_count - 1;
        if (m_count == 0) begin
          m_state = DONE;
          m_done  = 1'b1;
        end
      end else begin
        m_count = m_count + 1;
        if (m_count == 10000) begin
          m_count = 0;
          m_wrap  = 1'b1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, queue the model's expectation, then compare after the edge.
  task automatic cyc(input logic rst, t, s, p, c, l, input logic [15:0] lv, input logic dn);
    exp_t e;
    reset          = rst;
    bus.tick       = t;
    bus.start      = s;
    bus.stop       = p;
    bus.clear      = c;
    bus.load_en    = l;
    bus.load_value = lv;
    bus.count_down = dn;
    model_step(rst, t, s, p, c, l, lv, dn);
    e.digits  = to_bcd(m_count);
    e.running = (m_state == RUN);
    e.done    = m_done;
    e.wrap    = m_wrap;
    sb.push_back(e);
    @(posedge clk_in);
    #1;
    e = sb.pop_front();
    check_eq("digits",  32'(bus.digits),  32'(e.digits));
    check_eq("running", 32'(bus.running), 32'(e.running));
    check_eq("done",    32'(bus.done),    32'(e.done));
    check_eq("wrap",    32'(bus.wrap),    32'(e.wrap));
  endtask

  initial begin
    logic [15:0] lv;
    logic        dn;
    int          r;
    n_cmp = 0;
    n_err = 0;
    m_state = IDLE;
    m_count = 0;
    m_done  = 1'b0;
    m_wrap  = 1'b0;
    reset = 1'b1;
    bus.tick = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
    bus.load_en = 1'b0; bus.load_value = 16'h0000; bus.count_down = 1'b0;

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check_eq("rst_digits", 32'(bus.digits), 32'h0000_0000);
    check_eq("rst_running", 32'(bus.running), 32'h0000_0000);

    // Up count from reset; the pre-start tick must be ignored.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check_eq("tick_before_start", 32'(bus.digits), 32'h0000_0000);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check_eq("up12_digits", 32'(bus.digits), 32'h0000_0012);
    check_eq("up12_running", 32'(bus.running), 32'h0000_0001);

    // 9998 -> 9999 -> 0000 with a single wrap pulse.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h9998, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check_eq("wrap_9999", 32'(bus.digits), 32'h0000_9999);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check_eq("wrap_0000", 32'(bus.digits), 32'h0000_0000);
    check_eq("wrap_pulse", 32'(bus.wrap), 32'h0000_0001);
    check_eq("wrap_run", 32'(bus.running), 32'h0000_0001);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check_eq("wrap_one_cycle", 32'(bus.wrap), 32'h0000_0000);

    // Down count 0003 to DONE, then DONE ignores tick and start.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    check_eq("down_0001", 32'(bus.digits), 32'h0000_0001);
    check_eq("down_no_done", 32'(bus.done), 32'h0000_0000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    check_eq("down_0000", 32'(bus.digits), 32'h0000_0000);
    check_eq("done_pulse", 32'(bus.done), 32'h0000_0001);
    check_eq("done_not_running", 32'(bus.running), 32'h0000_0000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    check_eq("done_one_cycle", 32'(bus.done), 32'h0000_0000);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    check_eq("done_ignores_start", 32'(bus.running), 32'h0000_0000);

    // Stop with coincident tick, then resume for one tick.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    check_eq("stop_tick_digits", 32'(bus.digits), 32'h0000_0005);
    check_eq("stop_paused", 32'(bus.running), 32'h0000_0000);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check_eq("resume_plus1", 32'(bus.digits), 32'h0000_0006);

    // Saturated load, then clear beating a tick.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA5F9, 1'b0);
    check_eq("load_sat", 32'(bus.digits), 32'h0000_9599);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    check_eq("clear_tick", 32'(bus.digits), 32'h0000_0000);
    check_eq("clear_idle", 32'(bus.running), 32'h0000_0000);

    // Reset mid-count with coincident tick, load and start.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0456, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check_eq("pre_rst_0457", 32'(bus.digits), 32'h0000_0457);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
    check_eq("midrst_digits", 32'(bus.digits), 32'h0000_0000);
    check_eq("midrst_running", 32'(bus.running), 32'h0000_0000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check_eq("post_rst_tick", 32'(bus.digits), 32'h0000_0000);

    // Constrained-random traffic against the model.
    dn = 1'b0;
    for (int k = 0; k < 600; k++) begin
      r  = int'($urandom_range(0, 99));
      lv = 16'($urandom);
      if ($urandom_range(0, 19) == 0) dn = ~dn;
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 6), (r >= 15 && r < 30),
          (r >= 7 && r < 15), (r < 2), (r >= 2 && r < 6), lv, dn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
